// File: rtl/x_ram_unloader.sv
// X RAM unloader: reads X RAM words from address 0 upward and streams each one
// out as four big-endian bytes over a valid/ready byte interface.
package x_ram_unloader_pkg;
   localparam int unsigned REPRESENTATION_ADDR_WIDTH = 10;
endpackage

module x_ram_unloader
   import x_ram_unloader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = REPRESENTATION_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_sent
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      words_sent_q, words_sent_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [1:0]            idx_q, idx_d;
   logic [7:0]            out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Byte i of a word, counted from the most significant end.
   function automatic logic [7:0] sel_byte(input logic [DATA_WIDTH-1:0] w, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   always_comb begin
      state_d      = state_q;
      read_addr_d  = read_addr_q;
      count_d      = count_q;
      words_sent_d = words_sent_q;
      word_d       = word_q;
      idx_d        = idx_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               count_d      = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
               words_sent_d = '0;
               read_addr_d  = '0;
               state_d      = (word_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            word_d      = read_data;
            idx_d       = 2'd0;
            out_data_d  = sel_byte(read_data, 2'd0);
            out_valid_d = 1'b1;
            state_d     = SEND;
         end
         SEND: begin
            if (out_valid_q && out_ready) begin
               if (idx_q == 2'd3) begin
                  words_sent_d = words_sent_q + CNT_W'(1);
                  out_valid_d  = 1'b0;
                  // Stop on the last word so read_addr never wraps past the top.
                  if ((words_sent_q + CNT_W'(1)) < count_q) begin
                     read_addr_d = read_addr_q + ADDR_WIDTH'(1);
                     state_d     = FETCH;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  idx_d      = idx_q + 2'd1;
                  out_data_d = sel_byte(word_q, idx_q + 2'd1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         read_addr_q  <= '0;
         count_q      <= '0;
         words_sent_q <= '0;
         word_q       <= '0;
         idx_q        <= 2'd0;
         out_data_q   <= 8'd0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         read_addr_q  <= read_addr_d;
         count_q      <= count_d;
         words_sent_q <= words_sent_d;
         word_q       <= word_d;
         idx_q        <= idx_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign read_addr  = read_addr_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign words_sent = words_sent_q;

endmodule

// File: doc/x_ram_unloader.md
X_RAM_UNLOADER -- requirements
Module: x_ram_unloader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default REPRESENTATION_ADDR_WIDTH, giving the X RAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, fixed at 32: one fp_32_t Q15 word per RAM entry.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin an unload.
REQ-006 The block SHALL have port word_count, input, ADDR_WIDTH+1 bits: the number of words to unload, sampled when start is accepted.
REQ-007 The block SHALL have port read_addr, output, ADDR_WIDTH bits: the registered X RAM read address.
REQ-008 The block SHALL have port read_data, input, 32 bits: X RAM data, valid one clock edge after read_addr is presented.
REQ-009 The block SHALL have port out_data, output, 8 bits: the byte-stream data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the byte-stream valid flag.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the sink-ready flag.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse when an unload completes.
REQ-014 The block SHALL have port words_sent, output, ADDR_WIDTH+1 bits: the number of words fully transferred in the current or last unload.

Function
REQ-015 The block SHALL implement the inverse of the big-endian file loader: it reads X RAM words from address 0 upward and emits each word as 4 bytes, MSB first, i.e. bits [31:24], [23:16], [15:8], [7:0].
REQ-016 The FSM SHALL have exactly the states IDLE, FETCH, LATCH, SEND and DONE.
REQ-017 In IDLE, start=1 SHALL be accepted: latch word_count, clear words_sent, set read_addr<=0, and go to FETCH; if word_count==0, go directly to DONE instead.
REQ-018 FETCH SHALL last one cycle, during which the RAM registers ram[read_addr], and then go to LATCH.
REQ-019 In LATCH, the block SHALL load the shift register from read_data, set byte index<=0 and out_valid<=1, and go to SEND.
REQ-020 As a result of REQ-017 to REQ-019, out_valid SHALL first rise two edges after the edge that samples start.
REQ-021 A byte SHALL transfer on any edge where out_valid && out_ready.
REQ-022 In SEND, out_data SHALL equal the byte selected by the byte index.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-024 out_valid SHALL never drop without a transfer, except on reset.
REQ-025 On a transfer of byte index 3, the block SHALL increment words_sent and set out_valid<=0.
REQ-026 On that same edge, if words_sent+1 < latched count, the block SHALL set read_addr<=read_addr+1 and go to FETCH; otherwise it SHALL go to DONE.
REQ-027 DONE SHALL drive done=1 for exactly one cycle and then go to IDLE.
REQ-028 With out_ready held high, throughput SHALL be 6 cycles per word.
REQ-029 A start arriving in any state other than IDLE SHALL be ignored, with no effect on the count, address or stream.
REQ-030 A start in the same cycle as done=1 SHALL be ignored, because the FSM is in DONE.
REQ-031 word_count greater than 2^ADDR_WIDTH SHALL be clamped to 2^ADDR_WIDTH; read_addr SHALL NOT wrap within an unload.
REQ-032 word_count and read_data SHALL be treated as unsigned; no arithmetic SHALL be applied to the data, which passes through bit-exact.

Reset
REQ-033 On reset=1 at a clock edge the block SHALL set state=IDLE, read_addr=0, out_data=0, out_valid=0, busy=0, done=0 and words_sent=0.
REQ-034 Reset SHALL override start and out_ready in the same cycle.
REQ-035 Reset mid-unload SHALL abandon the word in flight with no further bytes emitted; the next start SHALL restart from address 0.

Verification
REQ-036 Scenario: X RAM[0]=0x12345678, RAM[1]=0xDEADBEEF, word_count=2, out_ready=1 -> bytes 12 34 56 78 DE AD BE EF; first out_valid 2 cycles after start; done pulses once; words_sent=2.
REQ-037 Scenario: word_count=0 -> no out_valid; done pulses on the edge after start; words_sent=0.
REQ-038 Scenario: out_ready low for 5 cycles on byte 0x56 -> out_data stays 0x56 with out_valid high for all 5 cycles; the stream then completes unchanged.
REQ-039 Scenario: start re-asserted while busy with word_count=1 -> ignored; the original 2-word stream completes; exactly one done pulse.
REQ-040 Scenario: reset asserted after the 2nd byte of word 0 -> next cycle out_valid=0, busy=0, words_sent=0; a new start emits from RAM[0] byte 0.
REQ-041 Scenario: word_count=2^ADDR_WIDTH with RAM[i]=i -> 4*2^ADDR_WIDTH bytes; the last word is 0x000003FF for the default width; read_addr never wraps.
